// File: rtl/ctl_formation.sv
// Formation controller: sweeps a shared base position right/left, steps it down at each
// edge and stops on the landing line. Movement is paced by frame_tick and gated by enable.
module ctl_formation #(
    parameter int X_START  = 100,
    parameter int Y_START  = 64,
    parameter int X_MIN    = 32,
    parameter int X_MAX    = 224,
    parameter int Y_MAX    = 400,
    parameter int SPEED    = 4,
    parameter int Y_STEP   = 16,
    parameter int MOVE_DIV = 2
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic        frame_tick,
    input  logic        enable,
    input  logic        restart,
    output logic [10:0] x_out,
    output logic [10:0] y_out,
    output logic        dir,
    output logic        landed
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        MOVE_R    = 3'd1,
        MOVE_L    = 3'd2,
        STEP_DOWN = 3'd3,
        LANDED    = 3'd4
    } state_t;

    localparam logic [11:0] X_MIN_W  = 12'(X_MIN);
    localparam logic [11:0] X_MAX_W  = 12'(X_MAX);
    localparam logic [11:0] Y_MAX_W  = 12'(Y_MAX);
    localparam logic [11:0] SPEED_W  = 12'(SPEED);
    localparam logic [11:0] Y_STEP_W = 12'(Y_STEP);
    localparam logic [10:0] X_START_O = 11'(X_START);
    localparam logic [10:0] Y_START_O = 11'(Y_START);
    localparam logic [10:0] X_MIN_O   = 11'(X_MIN);
    localparam logic [10:0] X_MAX_O   = 11'(X_MAX);
    localparam logic [10:0] Y_MAX_O   = 11'(Y_MAX);
    localparam logic [7:0]  CNT_LAST  = 8'(MOVE_DIV - 1);

    state_t      state_q, state_d;
    logic [10:0] x_q, x_d;
    logic [10:0] y_q, y_d;
    logic        dir_q, dir_d;
    logic        landed_q, landed_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        tick_prev_q, tick_prev_d;

    logic        rise_s;
    logic        cnt_en_s;
    logic        move_tick_s;
    logic [11:0] x_inc_s;
    logic [11:0] x_dec_s;
    logic [11:0] x_lim_s;
    logic [11:0] y_inc_s;

    // Only the first cycle of a frame_tick pulse counts; pacing stops while frozen or landed.
    assign rise_s      = frame_tick & ~tick_prev_q;
    assign cnt_en_s    = enable & (state_q != LANDED);
    assign move_tick_s = cnt_en_s & rise_s & (cnt_q == CNT_LAST);
    assign x_inc_s     = {1'b0, x_q} + SPEED_W;
    assign x_dec_s     = {1'b0, x_q} - SPEED_W;
    assign x_lim_s     = X_MIN_W + SPEED_W;
    assign y_inc_s     = {1'b0, y_q} + Y_STEP_W;

    assign x_out  = x_q;
    assign y_out  = y_q;
    assign dir    = dir_q;
    assign landed = landed_q;

    // Next-state, position and pacing counter; restart overrides everything else.
    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        dir_d       = dir_q;
        landed_d    = landed_q;
        cnt_d       = cnt_q;
        tick_prev_d = frame_tick;
        if (restart) begin
            state_d  = IDLE;
            x_d      = X_START_O;
            y_d      = Y_START_O;
            dir_d    = 1'b1;
            landed_d = 1'b0;
            cnt_d    = 8'd0;
        end else if (cnt_en_s) begin
            if (move_tick_s) begin
                cnt_d = 8'd0;
            end else if (rise_s) begin
                cnt_d = cnt_q + 8'd1;
            end else begin
                cnt_d = cnt_q;
            end
            case (state_q)
                IDLE: begin
                    state_d = MOVE_R;
                    dir_d   = 1'b1;
                end
                MOVE_R: begin
                    if (move_tick_s && (x_inc_s >= X_MAX_W)) begin
                        x_d     = X_MAX_O;
                        state_d = STEP_DOWN;
                    end else if (move_tick_s) begin
                        x_d = x_inc_s[10:0];
                    end else begin
                        x_d = x_q;
                    end
                end
                MOVE_L: begin
                    // Compare against X_MIN+SPEED so the subtraction never wraps.
                    if (move_tick_s && ({1'b0, x_q} <= x_lim_s)) begin
                        x_d     = X_MIN_O;
                        state_d = STEP_DOWN;
                    end else if (move_tick_s) begin
                        x_d = x_dec_s[10:0];
                    end else begin
                        x_d = x_q;
                    end
                end
                STEP_DOWN: begin
                    if (move_tick_s && (y_inc_s >= Y_MAX_W)) begin
                        y_d      = Y_MAX_O;
                        landed_d = 1'b1;
                        state_d  = LANDED;
                    end else if (move_tick_s) begin
                        y_d     = y_inc_s[10:0];
                        dir_d   = ~dir_q;
                        state_d = dir_q ? MOVE_L : MOVE_R;
                    end else begin
                        y_d = y_q;
                    end
                end
                LANDED: begin
                    state_d = LANDED;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            x_q         <= X_START_O;
            y_q         <= Y_START_O;
            dir_q       <= 1'b1;
            landed_q    <= 1'b0;
            cnt_q       <= 8'd0;
            tick_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            dir_q       <= dir_d;
            landed_q    <= landed_d;
            cnt_q       <= cnt_d;
            tick_prev_q <= tick_prev_d;
        end
    end

endmodule

// File: tb/tb_ctl_formation.sv
// Directed bench for ctl_formation: a default-parameter instance for sweep/pacing/restart
// and a narrow, fast instance for the left clamp and the landing sequence.
module tb_ctl_formation;

    logic        pclk = 1'b0;
    logic        rst = 1'b1;
    logic        frame_tick = 1'b0;
    logic        restart = 1'b0;
    logic        en1 = 1'b0;
    logic        en2 = 1'b0;
    logic [10:0] x1, y1, x2, y2;
    logic        dir1, landed1, dir2, landed2;
    int          n_checks = 0;
    int          n_errors = 0;

    logic [10:0] exp_x2 [15] = '{11'd46, 11'd50, 11'd50, 11'd46, 11'd42, 11'd38, 11'd34, 11'd32,
                                 11'd32, 11'd36, 11'd40, 11'd44, 11'd48, 11'd50, 11'd50};
    logic [10:0] exp_y2 [15] = '{11'd360, 11'd360, 11'd376, 11'd376, 11'd376, 11'd376, 11'd376,
                                 11'd376, 11'd392, 11'd392, 11'd392, 11'd392, 11'd392, 11'd392,
                                 11'd400};

    always #5 pclk = ~pclk;

    ctl_formation dut1 (
        .pclk(pclk), .rst(rst), .frame_tick(frame_tick), .enable(en1), .restart(restart),
        .x_out(x1), .y_out(y1), .dir(dir1), .landed(landed1)
    );

    ctl_formation #(
        .X_START(42), .Y_START(360), .X_MIN(32), .X_MAX(50), .Y_MAX(400),
        .SPEED(4), .Y_STEP(16), .MOVE_DIV(1)
    ) dut2 (
        .pclk(pclk), .rst(rst), .frame_tick(frame_tick), .enable(en2), .restart(restart),
        .x_out(x2), .y_out(y2), .dir(dir2), .landed(landed2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(negedge pclk) frame_tick = 1'b1;
        @(negedge pclk) frame_tick = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #1 rst = 1'b0;
        repeat (3) @(negedge pclk);
        chk("rst_x1", 32'(x1), 32'd100);
        chk("rst_y1", 32'(y1), 32'd64);
        chk("rst_dir1", 32'(dir1), 32'd1);
        chk("rst_landed1", 32'(landed1), 32'd0);
        chk("rst_state1", 32'(dut1.state_q), 32'd0);
        chk("rst_x2", 32'(x2), 32'd42);
        rst = 1'b1;

        @(negedge pclk) en1 = 1'b1;
        @(negedge pclk);
        chk("idle_to_mover", 32'(dut1.state_q), 32'd1);

        // Enable dropped mid-count keeps the partial count.
        tick();
        chk("half_count_x", 32'(x1), 32'd100);
        en1 = 1'b0;
        repeat (5) tick();
        chk("frozen_x", 32'(x1), 32'd100);
        en1 = 1'b1;
        tick();
        chk("resume_x", 32'(x1), 32'd104);

        for (int i = 3; i <= 62; i++) begin
            tick();
            chk("sweep_r_x", 32'(x1), 32'(100 + 4 * (i / 2)));
        end
        chk("sweep_r_y", 32'(y1), 32'd64);
        chk("sweep_r_state", 32'(dut1.state_q), 32'd3);
        chk("sweep_r_dir", 32'(dir1), 32'd1);

        tick();
        tick();
        chk("step_y", 32'(y1), 32'd80);
        chk("step_x", 32'(x1), 32'd224);
        chk("step_dir", 32'(dir1), 32'd0);
        chk("step_state", 32'(dut1.state_q), 32'd2);
        tick();
        tick();
        chk("first_left_x", 32'(x1), 32'd220);

        // Restart coinciding with a completing frame tick.
        tick();
        @(negedge pclk);
        frame_tick = 1'b1;
        restart = 1'b1;
        @(negedge pclk);
        frame_tick = 1'b0;
        restart = 1'b0;
        chk("restart_x", 32'(x1), 32'd100);
        chk("restart_y", 32'(y1), 32'd64);
        chk("restart_dir", 32'(dir1), 32'd1);
        chk("restart_landed", 32'(landed1), 32'd0);
        chk("restart_state", 32'(dut1.state_q), 32'd0);

        // A long frame_tick pulse counts once.
        @(negedge pclk);
        frame_tick = 1'b1;
        repeat (6) @(negedge pclk);
        frame_tick = 1'b0;
        chk("long_pulse_x", 32'(x1), 32'd100);
        tick();
        chk("long_pulse_next_x", 32'(x1), 32'd104);

        // Reset mid-count discards the partial count.
        tick();
        @(negedge pclk);
        rst = 1'b0;
        #1;
        chk("async_rst_x", 32'(x1), 32'd100);
        @(negedge pclk) rst = 1'b1;
        @(negedge pclk);
        tick();
        chk("post_rst_first_x", 32'(x1), 32'd100);
        tick();
        chk("post_rst_second_x", 32'(x1), 32'd104);
        en1 = 1'b0;

        // Narrow instance: left clamp at X_MIN, then landing.
        @(negedge pclk) en2 = 1'b1;
        @(negedge pclk);
        for (int i = 0; i < 15; i++) begin
            tick();
            chk("fast_x", 32'(x2), 32'(exp_x2[i]));
            chk("fast_y", 32'(y2), 32'(exp_y2[i]));
            if (i == 2) chk("fast_dir_left", 32'(dir2), 32'd0);
            if (i == 6) chk("pre_clamp_state", 32'(dut2.state_q), 32'd2);
            if (i == 7) chk("clamp_state", 32'(dut2.state_q), 32'd3);
            if (i == 13) chk("pre_land_state", 32'(dut2.state_q), 32'd3);
            if (i == 13) chk("pre_land_landed", 32'(landed2), 32'd0);
        end
        chk("land_landed", 32'(landed2), 32'd1);
        chk("land_state", 32'(dut2.state_q), 32'd4);
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("held_x", 32'(x2), 32'd50);
            chk("held_y", 32'(y2), 32'd400);
        end
        chk("held_dir", 32'(dir2), 32'd1);
        chk("held_landed", 32'(landed2), 32'd1);

        @(negedge pclk) restart = 1'b1;
        @(negedge pclk) restart = 1'b0;
        chk("fast_restart_x", 32'(x2), 32'd42);
        chk("fast_restart_y", 32'(y2), 32'd360);
        chk("fast_restart_dir", 32'(dir2), 32'd1);
        chk("fast_restart_landed", 32'(landed2), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ctl_formation.md
CTL_FORMATION -- requirements
Module: ctl_formation

Interface
REQ-001 SHALL have parameter X_START, default 100: formation base x after reset or restart.
REQ-002 SHALL have parameter Y_START, default 64: formation base y after reset or restart.
REQ-003 SHALL have parameter X_MIN, default 32: leftmost legal base x.
REQ-004 SHALL have parameter X_MAX, default 224: rightmost legal base x; the formation span is already subtracted.
REQ-005 SHALL have parameter Y_MAX, default 400: landing line for base y.
REQ-006 SHALL have parameter SPEED, default 4: pixels moved per move tick.
REQ-007 SHALL have parameter Y_STEP, default 16: pixels dropped per step-down.
REQ-008 SHALL have parameter MOVE_DIV, default 2: frame ticks per move tick, range 1..255.
REQ-009 SHALL have port pclk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-010 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-011 SHALL have port frame_tick, input, 1 bit: one-cycle pulse per video frame.
REQ-012 SHALL have port enable, input, 1 bit: while high, the formation is allowed to move.
REQ-013 SHALL have port restart, input, 1 bit: synchronous return to the start position.
REQ-014 SHALL have port x_out, output, 11 bits: formation base x, which feeds every per-enemy x input.
REQ-015 SHALL have port y_out, output, 11 bits: formation base y, which feeds every per-enemy y input.
REQ-016 SHALL have port dir, output, 1 bit: current horizontal direction, 1 = right.
REQ-017 SHALL have port landed, output, 1 bit: high once the formation reaches Y_MAX.

Function
REQ-018 SHALL implement these FSM states: IDLE, MOVE_R, MOVE_L, STEP_DOWN, LANDED.
REQ-019 SHALL count frame_tick pulses only while enable=1 and the state is not LANDED; when the count is MOVE_DIV-1 and frame_tick=1, it SHALL generate an internal move_tick and clear the count.
REQ-020 SHALL update x_out and y_out on the clock edge that generates move_tick, so they are registered one cycle after that frame_tick.
REQ-021 SHALL, in IDLE with enable=1, go to MOVE_R on the next cycle, with dir=1.
REQ-022 SHALL, in MOVE_R on move_tick: if x_out+SPEED >= X_MAX, set x_out=X_MAX and go to STEP_DOWN; otherwise set x_out = x_out+SPEED.
REQ-023 SHALL, in MOVE_L on move_tick: if x_out <= X_MIN+SPEED, set x_out=X_MIN and go to STEP_DOWN; otherwise set x_out = x_out-SPEED. The compare is written this way so it never underflows.
REQ-024 SHALL, in STEP_DOWN on move_tick: if y_out+Y_STEP >= Y_MAX, set y_out=Y_MAX, set landed=1 and go to LANDED; otherwise set y_out = y_out+Y_STEP, invert dir, and go to MOVE_R if the new dir=1, else MOVE_L.
REQ-025 SHALL leave x_out unchanged in STEP_DOWN and y_out unchanged in the MOVE states.
REQ-026 SHALL hold all outputs in LANDED until restart or reset.
REQ-027 SHALL perform all arithmetic at 12-bit width internally; outputs never exceed X_MAX or Y_MAX and are never below X_MIN.
REQ-028 SHALL, while enable=0, freeze the state, position, dir and frame counter; when enable returns high, it SHALL resume without losing the partial count.
REQ-029 SHALL, when restart=1 on any clock edge, force x_out=X_START, y_out=Y_START, dir=1, landed=0, frame count 0 and state IDLE, with priority over frame_tick and move_tick in the same cycle.
REQ-030 SHALL ignore frame_tick pulses that are longer than one cycle beyond their first cycle, using edge detection on frame_tick.

Reset
REQ-031 SHALL, while rst=0 (asynchronously), set x_out=X_START, y_out=Y_START, dir=1, landed=0, state IDLE and frame count 0.
REQ-032 SHALL, when rst is asserted mid-move or mid-step-down, discard any pending move_tick; the first movement after release requires a full MOVE_DIV frames.

Verification
REQ-033 SHALL cover: defaults, enable=1, 62 frame_ticks -> x_out goes 100,104,...,224 every 2nd tick, state becomes STEP_DOWN, y_out stays 64.
REQ-034 SHALL cover: continue from REQ-033, 2 more frame_ticks -> y_out=80, x_out=224, dir=0; the next move tick gives x_out=220.
REQ-035 SHALL cover: X_MIN edge, SPEED=4, x_out=34 in MOVE_L, one move tick -> x_out=32 (clamped, no wrap), state STEP_DOWN.
REQ-036 SHALL cover: y_out=392, STEP_DOWN, one move tick -> y_out=400, landed=1; a further 20 frame_ticks leave all outputs unchanged.
REQ-037 SHALL cover: restart and a completing frame_tick in the same cycle -> x_out=100, y_out=64, dir=1, landed=0, state IDLE.
REQ-038 SHALL cover: enable dropped after 1 of 2 frame_ticks, 5 ticks while low, then enable raised and 1 tick -> exactly one move of +4.
